// File: rtl/led_driver.sv
// LED output driver: per-LED OFF/ON/BLINK/STRETCH modes with PWM brightness,
// configured through a valid/ready command port that takes one command every two cycles.
module led_driver #(
    parameter int WIDTH          = 4,
    parameter int PWM_BITS       = 4,
    parameter int TICK_COUNT_MAX = 62500,
    parameter int BLINK_TICKS    = 500,
    parameter int STRETCH_TICKS  = 200,
    localparam int SEL_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    ev_in,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SEL_W-1:0]    cmd_sel,
    input  logic [1:0]          cmd_mode,
    input  logic [PWM_BITS-1:0] cmd_duty,
    output logic [WIDTH-1:0]    led_out
);

    localparam int TICK_W  = $clog2(TICK_COUNT_MAX);
    localparam int BLINK_W = $clog2(BLINK_TICKS + 1);
    localparam int STR_W   = $clog2(STRETCH_TICKS + 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_STRETCH = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_capSel;
    mode_t               r_capMode;
    logic [PWM_BITS-1:0] r_capDuty;
    mode_t               r_mode   [WIDTH];
    logic [PWM_BITS-1:0] r_duty   [WIDTH];
    logic [STR_W-1:0]    r_stretch[WIDTH];

    logic [TICK_W-1:0]   r_tickCnt;
    logic [BLINK_W-1:0]  r_blinkCnt;
    logic                r_blinkPhase;
    logic [PWM_BITS-1:0] r_pwmCnt;

    logic                w_tick;
    logic                w_apply;
    logic [WIDTH-1:0]    w_enable;
    logic [WIDTH-1:0]    w_pwmOn;

    assign w_tick  = (r_tickCnt == TICK_W'(TICK_COUNT_MAX - 1));
    assign w_apply = (r_state == ST_APPLY);

    // Shared timebase: prescaler tick, blink phase and free-running PWM counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tickCnt    <= '0;
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
            r_pwmCnt     <= '0;
        end else begin
            r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
            if (w_tick) begin
                r_tickCnt <= '0;
                if (r_blinkCnt == BLINK_W'(BLINK_TICKS - 1)) begin
                    r_blinkCnt   <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
                end
            end else begin
                r_tickCnt <= r_tickCnt + TICK_W'(1);
            end
        end
    end

    // Command FSM; an out-of-range select matches no LED and is silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
            r_capSel  <= '0;
            r_capMode <= MODE_OFF;
            r_capDuty <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_duty[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_capSel  <= cmd_sel;
                        r_capMode <= mode_t'(cmd_mode);
                        r_capDuty <= cmd_duty;
                        r_state   <= ST_APPLY;
                        cmd_ready <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_capSel == SEL_W'(i)) begin
                            r_mode[i] <= r_capMode;
                            r_duty[i] <= r_capDuty;
                        end
                    end
                    r_state   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Reconfiguring an LED cancels its stretch; otherwise an event reload beats a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_apply && (r_capSel == SEL_W'(i))) begin
                    r_stretch[i] <= '0;
                end else if (ev_in[i] && (r_mode[i] == MODE_STRETCH)) begin
                    r_stretch[i] <= STR_W'(STRETCH_TICKS);
                end else if (w_tick && (r_stretch[i] != '0)) begin
                    r_stretch[i] <= r_stretch[i] - STR_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_enable = '0;
        w_pwmOn  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pwmOn[i] = (r_duty[i] == '1) || (r_pwmCnt < r_duty[i]);
            case (r_mode[i])
                MODE_OFF:     w_enable[i] = 1'b0;
                MODE_ON:      w_enable[i] = 1'b1;
                MODE_BLINK:   w_enable[i] = r_blinkPhase;
                MODE_STRETCH: w_enable[i] = (r_stretch[i] != '0);
                default:      w_enable[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= w_enable & w_pwmOn;
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// Randomized bench for led_driver: a cycle-indexed arithmetic model predicts
// led_out and cmd_ready after every clock edge.
module tb_led_driver;

    localparam int WIDTH    = 4;
    localparam int PWM_BITS = 4;
    localparam int TICK     = 10;
    localparam int BLINK    = 5;
    localparam int STRETCH  = 3;
    localparam int DUTY_MAX = (1 << PWM_BITS) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [WIDTH-1:0]    ev_in;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_sel;
    logic [1:0]          cmd_mode;
    logic [PWM_BITS-1:0] cmd_duty;
    logic [WIDTH-1:0]    led_out;

    always #5 clk = ~clk;

    led_driver #(
        .WIDTH(WIDTH),
        .PWM_BITS(PWM_BITS),
        .TICK_COUNT_MAX(TICK),
        .BLINK_TICKS(BLINK),
        .STRETCH_TICKS(STRETCH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ev_in(ev_in),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel),
        .cmd_mode(cmd_mode),
        .cmd_duty(cmd_duty),
        .led_out(led_out)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference state: edges since reset release plus the per-LED configuration.
    int         edgeNum;
    int         mMode[WIDTH];
    int         mDuty[WIDTH];
    int         mStretch[WIDTH];
    bit         mPending;
    int         capSel, capMode, capDuty;
    bit         accepted;
    logic [WIDTH-1:0] expLed;
    logic       expReady;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at t=%0t edge %0d: got %0h, expected %0h",
                     tag, $time, edgeNum, observed, expected);
        end
    endtask

    task automatic modelReset();
        edgeNum  = 0;
        mPending = 1'b0;
        accepted = 1'b0;
        expLed   = '0;
        expReady = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            mMode[i]    = 0;
            mDuty[i]    = 0;
            mStretch[i] = 0;
        end
    endtask

    // Advance the model by one clock edge given the inputs present before that edge.
    task automatic modelEdge(input logic [WIDTH-1:0] ev, input bit cv,
                             input int sel, input int mode, input int duty);
        int pre, pwm, phase;
        bit tick, lit, en;
        pre   = edgeNum;
        pwm   = pre % (DUTY_MAX + 1);
        phase = (pre / (TICK * BLINK)) % 2;
        tick  = ((pre % TICK) == TICK - 1);
        for (int i = 0; i < WIDTH; i++) begin
            lit = (mDuty[i] == DUTY_MAX) || (pwm < mDuty[i]);
            case (mMode[i])
                1:       en = 1'b1;
                2:       en = (phase == 1);
                3:       en = (mStretch[i] != 0);
                default: en = 1'b0;
            endcase
            expLed[i] = en && lit;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (mPending && capSel == i)          mStretch[i] = 0;
            else if (ev[i] && mMode[i] == 3)      mStretch[i] = STRETCH;
            else if (tick && mStretch[i] > 0)     mStretch[i] = mStretch[i] - 1;
        end
        accepted = 1'b0;
        if (mPending) begin
            if (capSel < WIDTH) begin
                mMode[capSel] = capMode;
                mDuty[capSel] = capDuty;
            end
            mPending = 1'b0;
        end else if (cv) begin
            capSel   = sel;
            capMode  = mode;
            capDuty  = duty;
            mPending = 1'b1;
            accepted = 1'b1;
        end
        expReady = !mPending;
        edgeNum  = pre + 1;
    endtask

    task automatic newCommand();
        cmd_valid = 1'b1;
        cmd_sel   = 2'($urandom_range(0, WIDTH - 1));
        cmd_mode  = 2'($urandom_range(0, 3));
        cmd_duty  = ($urandom_range(0, 1) == 1) ? PWM_BITS'(DUTY_MAX)
                                                 : PWM_BITS'($urandom_range(0, DUTY_MAX));
    endtask

    task automatic applyStimulus(input int cycles, input bit allowCmd);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            modelEdge(ev_in, cmd_valid, int'(cmd_sel), int'(cmd_mode), int'(cmd_duty));
            #1;
            checkOutput("led_out", 32'(led_out), 32'(expLed));
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(expReady));
            for (int i = 0; i < WIDTH; i++) begin
                ev_in[i] = ($urandom_range(0, 39) == 0);
            end
            if (cmd_valid && !accepted) begin
                // requester holds its command until accepted
            end else if (allowCmd && (accepted ? ($urandom_range(0, 2) == 0)
                                               : ($urandom_range(0, 15) == 0))) begin
                newCommand();
            end else begin
                cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic holdReset();
        ev_in     = '0;
        cmd_valid = 1'b0;
        cmd_sel   = '0;
        cmd_mode  = '0;
        cmd_duty  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("rst_led", 32'(led_out), 32'(0));
            checkOutput("rst_ready", 32'(cmd_ready), 32'(1));
        end
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        rst_n = 1'b0;
        modelReset();
        holdReset();
        applyStimulus(60, 1'b0);
        applyStimulus(3000, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_led", 32'(led_out), 32'(0));
        checkOutput("async_ready", 32'(cmd_ready), 32'(1));
        holdReset();
        applyStimulus(120, 1'b0);
        applyStimulus(2000, 1'b1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
